// File: rtl/cdc_xfer_arbiter_if.sv
// Bundles the requester, transfer-channel and error signals of cdc_xfer_arbiter.
// The arbiter uses the slave modport. Requesters and the destination side use the master modport.
interface cdc_xfer_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        i_req;
  logic [NUM_REQ*DATA_W-1:0] i_data;
  logic [NUM_REQ-1:0]        o_gnt;
  logic                      o_xfer_req;
  logic [DATA_W-1:0]         o_xfer_data;
  logic                      i_xfer_ack;
  logic                      o_busy;
  logic [ID_W-1:0]           o_xfer_id;
  logic                      i_err_clr;
  logic                      o_err;

  modport slave (
    input  i_req, i_data, i_xfer_ack, i_err_clr,
    output o_gnt, o_xfer_req, o_xfer_data, o_busy, o_xfer_id, o_err
  );

  modport master (
    output i_req, i_data, i_xfer_ack, i_err_clr,
    input  o_gnt, o_xfer_req, o_xfer_data, o_busy, o_xfer_id, o_err
  );
endinterface

// File: rtl/cdc_xfer_arbiter.sv
// Round-robin arbiter sharing one four-phase req/ack CDC channel among NUM_REQ requesters.
// Optional handshake timeout with a sticky error flag is built when CDC_XFER_TIMEOUT_EN is defined.
module cdc_xfer_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input logic                i_clk,
  input logic                i_rst_n,
  cdc_xfer_arbiter_if.slave  bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, REQ_HI, WAIT_LO} state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  ack_sync_q, ack_sync_d;
  logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]         xfer_id_q, xfer_id_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic                    xfer_req_q, xfer_req_d;
  logic [DATA_W-1:0]       xfer_data_q, xfer_data_d;

  logic                    ack_s;
  logic                    win_found;
  logic [ID_W-1:0]         win_idx;
  logic [DATA_W-1:0]       win_word;
  logic [ID_W:0]           cand_sum;
  logic [ID_W-1:0]         cand;
  logic                    timeout_hit;

  // The ack is the only signal from the destination domain; nothing else looks at it raw.
  always_comb begin
    ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], bus.i_xfer_ack};
  end
  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
      if (cand_sum >= (ID_W+1)'(NUM_REQ)) cand_sum = cand_sum - (ID_W+1)'(NUM_REQ);
      cand = cand_sum[ID_W-1:0];
      if (!win_found && bus.i_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_word = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == ID_W'(k)) win_word = bus.i_data[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = '0;
    xfer_req_d  = xfer_req_q;
    xfer_data_d = xfer_data_q;
    xfer_id_d   = xfer_id_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d       = NUM_REQ'(1) << win_idx;
          xfer_data_d = win_word;
          xfer_id_d   = win_idx;
          xfer_req_d  = 1'b1;
          rr_ptr_d    = (win_idx == ID_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
          state_d     = REQ_HI;
        end
      end
      REQ_HI: begin
        if (ack_s || timeout_hit) begin
          xfer_req_d = 1'b0;
          state_d    = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!ack_s || timeout_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      ack_sync_q  <= '0;
      rr_ptr_q    <= '0;
      xfer_id_q   <= '0;
      gnt_q       <= '0;
      xfer_req_q  <= 1'b0;
      xfer_data_q <= '0;
    end else begin
      state_q     <= state_d;
      ack_sync_q  <= ack_sync_d;
      rr_ptr_q    <= rr_ptr_d;
      xfer_id_q   <= xfer_id_d;
      gnt_q       <= gnt_d;
      xfer_req_q  <= xfer_req_d;
      xfer_data_q <= xfer_data_d;
    end
  end

`ifdef CDC_XFER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             err_set;

  assign timeout_hit = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYC-1));
  // Only a timeout that actually forces the exit counts as an error; a normal ack exit wins.
  assign err_set = timeout_hit &&
                   ((state_q == REQ_HI && !ack_s) || (state_q == WAIT_LO && ack_s));

  always_comb begin
    cnt_d = '0;
    if (state_d == state_q && state_q != IDLE) cnt_d = cnt_q + 1'b1;
    err_d = err_q;
    if (err_set)            err_d = 1'b1;
    else if (bus.i_err_clr) err_d = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.o_err = err_q;
`else
  localparam int UNUSED_TIMEOUT_CYC = TIMEOUT_CYC;
  logic unused_err_clr;

  assign timeout_hit    = 1'b0;
  assign unused_err_clr = bus.i_err_clr;
  assign bus.o_err      = 1'b0;
`endif

  assign bus.o_gnt       = gnt_q;
  assign bus.o_xfer_req  = xfer_req_q;
  assign bus.o_xfer_data = xfer_data_q;
  assign bus.o_xfer_id   = xfer_id_q;
  assign bus.o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// Scoreboard bench for cdc_xfer_arbiter: an abstract round-robin model predicts the grant
// sequence per request batch, and a monitor checks every grant and the channel data stability.
`timescale 1ns/100ps
module tb_cdc_xfer_arbiter;
  localparam int NUM_REQ     = 4;
  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT_CYC = 16;

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic dst_clk;
  logic rst_n;
  logic ack_en;

  int         checks = 0;
  int         passes = 0;
  int         model_ptr = 0;
  exp_t       exp_q[$];
  logic [7:0] word_tbl [4];
  logic [7:0] hold_data = '0;
  logic       prev_req = 1'b0;

  cdc_xfer_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  cdc_xfer_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_W     (DATA_W),
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  // Source clock 10 ns; destination clock runs unrelated at 7.4 ns.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    dst_clk = 1'b0;
    forever #3.7 dst_clk = ~dst_clk;
  end

  // Destination model: echoes o_xfer_req after three dest cycles, with random output phase.
  initial begin
    logic [2:0] ack_pipe;
    ack_pipe = '0;
    bus.i_xfer_ack = 1'b0;
    forever begin
      @(posedge dst_clk);
      if (!rst_n || !ack_en) begin
        ack_pipe = '0;
        bus.i_xfer_ack = 1'b0;
      end else begin
        ack_pipe = {ack_pipe[1:0], bus.o_xfer_req};
        #($urandom_range(0, 3));
        bus.i_xfer_ack = ack_pipe[2];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
  endtask

  task automatic failNow(input string name);
    checks++;
    $display("[TB] FAIL %s: bounded wait expired at %0t", name, $time);
  endtask

  // Reference model: successive winners are the first pending requester at or after the pointer.
  // Non-sticky requesters leave the pending set once granted; sticky ones keep re-requesting.
  task automatic predictGrants(input logic [3:0] set, input int count, input bit sticky);
    logic [3:0] pend;
    int c;
    pend = set;
    for (int g = 0; g < count; g++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        c = (model_ptr + i) % NUM_REQ;
        if (pend[c]) begin
          exp_q.push_back('{id: c, data: word_tbl[c]});
          if (!sticky) pend[c] = 1'b0;
          model_ptr = (c + 1) % NUM_REQ;
          break;
        end
      end
    end
  endtask

  task automatic loadWords();
    for (int k = 0; k < NUM_REQ; k++) bus.i_data[k*DATA_W +: DATA_W] = word_tbl[k];
  endtask

  // Raise a batch of requests together; each requester drops its line once it sees its grant.
  task automatic applyStimulus(input logic [3:0] set);
    int n;
    predictGrants(set, $countones(set), 1'b0);
    loadWords();
    bus.i_req = set;
    n = 0;
    while (n < 3000) begin
      @(negedge clk);
      n++;
      bus.i_req = bus.i_req & ~bus.o_gnt;
      if (bus.i_req == '0 && !bus.o_busy && exp_q.size() == 0) break;
    end
    if (n >= 3000) failNow("batch_drain");
  endtask

  task automatic waitGrant();
    int n;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (bus.o_gnt != '0) break;
    end
    if (n >= 200) failNow("grant_wait");
  endtask

  // Monitor: pops the scoreboard on each grant and checks the holding register while req is high.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req = 1'b0;
      end else begin
        if (bus.o_gnt != '0) begin
          if (exp_q.size() == 0) begin
            checkOutput("gnt_unexpected", 32'(bus.o_gnt), 32'd0);
          end else begin
            e = exp_q.pop_front();
            checkOutput("gnt_onehot", 32'(bus.o_gnt), 32'd1 << e.id);
            checkOutput("xfer_id", 32'(bus.o_xfer_id), 32'(e.id));
            checkOutput("xfer_data", 32'(bus.o_xfer_data), 32'(e.data));
            checkOutput("xfer_req_at_gnt", 32'(bus.o_xfer_req), 32'd1);
            checkOutput("busy_at_gnt", 32'(bus.o_busy), 32'd1);
            hold_data = e.data;
          end
        end else if (bus.o_xfer_req) begin
          checkOutput("data_stable", 32'(bus.o_xfer_data), 32'(hold_data));
        end
        if (prev_req && !bus.o_xfer_req) checkOutput("busy_at_req_fall", 32'(bus.o_busy), 32'd1);
        prev_req = bus.o_xfer_req;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst_n         = 1'b0;
    ack_en        = 1'b1;
    bus.i_req     = '0;
    bus.i_data    = '0;
    bus.i_err_clr = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) word_tbl[k] = '0;

    // Outputs while held in reset.
    repeat (3) @(negedge clk);
    checkOutput("rst_gnt", 32'(bus.o_gnt), 32'd0);
    checkOutput("rst_xfer_req", 32'(bus.o_xfer_req), 32'd0);
    checkOutput("rst_xfer_data", 32'(bus.o_xfer_data), 32'd0);
    checkOutput("rst_busy", 32'(bus.o_busy), 32'd0);
    checkOutput("rst_xfer_id", 32'(bus.o_xfer_id), 32'd0);
    checkOutput("rst_err", 32'(bus.o_err), 32'd0);
    rst_n = 1'b1;

    // All four requesting continuously from reset: order 0,1,2,3,0,1.
    for (int k = 0; k < NUM_REQ; k++) word_tbl[k] = 8'h10 + 8'(k);
    predictGrants(4'b1111, 6, 1'b1);
    loadWords();
    bus.i_req = 4'b1111;
    n = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (bus.o_gnt != '0) n++;
      if (n >= 6) bus.i_req = '0;
      if (n >= 6 && !bus.o_busy && exp_q.size() == 0) break;
    end
    checkOutput("continuous_grants", 32'(n), 32'd6);

    // Single request carrying 8'hA5 from requester 1.
    word_tbl[1] = 8'hA5;
    applyStimulus(4'b0010);

    // Reset in REQ_HI, then requester 3 alone after release.
    word_tbl[2] = 8'h5C;
    predictGrants(4'b0100, 1, 1'b0);
    loadWords();
    bus.i_req = 4'b0100;
    waitGrant();
    bus.i_req = '0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_xfer_req", 32'(bus.o_xfer_req), 32'd0);
    checkOutput("midrst_gnt", 32'(bus.o_gnt), 32'd0);
    checkOutput("midrst_busy", 32'(bus.o_busy), 32'd0);
    model_ptr = 0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    word_tbl[3] = 8'hC3;
    rst_n = 1'b1;
    applyStimulus(4'b1000);

    // Pointer wrap: after granting 3, requesters 1 and 3 -> 1 then 3.
    word_tbl[1] = 8'h61;
    word_tbl[3] = 8'h63;
    applyStimulus(4'b1010);

    // Random batches with random words under random ack phase.
    for (int b = 0; b < 25; b++) begin
      for (int k = 0; k < NUM_REQ; k++) word_tbl[k] = 8'($urandom);
      applyStimulus(4'($urandom_range(1, 15)));
    end

`ifdef CDC_XFER_TIMEOUT_EN
    // Ack held low: request must drop 16 cycles after rising and the error must latch.
    ack_en = 1'b0;
    word_tbl[0] = 8'h3E;
    predictGrants(4'b0001, 1, 1'b0);
    loadWords();
    bus.i_req = 4'b0001;
    waitGrant();
    bus.i_req = '0;
    n = 0;
    while (bus.o_xfer_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("timeout_req_len", 32'(n), 32'd16);
    checkOutput("timeout_err_set", 32'(bus.o_err), 32'd1);
    n = 0;
    while (bus.o_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("timeout_idle", 32'(bus.o_busy), 32'd0);
    checkOutput("timeout_err_sticky", 32'(bus.o_err), 32'd1);
    bus.i_err_clr = 1'b1;
    @(negedge clk);
    bus.i_err_clr = 1'b0;
    checkOutput("err_cleared", 32'(bus.o_err), 32'd0);
    ack_en = 1'b1;
    repeat (4) @(negedge clk);
`else
    // Without the timeout feature the error flag ignores the clear input.
    bus.i_err_clr = 1'b1;
    @(negedge clk);
    bus.i_err_clr = 1'b0;
    checkOutput("err_tied_low", 32'(bus.o_err), 32'd0);
`endif

    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cdc_xfer_arbiter.md
Name: cdc_xfer_arbiter

Overview:
- Source-domain controller that shares one multi-bit CDC transfer channel among NUM_REQ requesters.
- Arbitrates round-robin and captures the winner's word into a stable holding register.
- Drives a four-phase req/ack handshake toward the destination domain; the incoming ack is synchronised internally.
- Covers data that is not monotonic, where Gray-code crossing is not usable.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_W, 8, transfer word width.
- SYNC_STAGES, 2, flops in the ack synchroniser (>=2).
- TIMEOUT_CYC, 64, handshake timeout in i_clk cycles; used only when CDC_XFER_TIMEOUT_EN is defined.

Ports:
- i_clk  in  1  source-domain clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req  in  NUM_REQ  per-requester request level; held until granted.
- i_data  in  NUM_REQ*DATA_W  per-requester word; requester k occupies bits [k*DATA_W +: DATA_W].
- o_gnt  out  NUM_REQ  one-hot, one-cycle pulse; winner's word has been captured.
- o_xfer_req  out  1  four-phase request to destination domain (registered).
- o_xfer_data  out  DATA_W  holding register; stable whenever o_xfer_req=1.
- i_xfer_ack  in  1  asynchronous ack from destination domain.
- o_busy  out  1  high in any state other than IDLE.
- o_xfer_id  out  $clog2(NUM_REQ)  index of the requester owning the current/last transfer.
- i_err_clr  in  1  clears o_err.
- o_err  out  1  sticky timeout flag.

Behaviour:
- Reset (async assert, sync release): state=IDLE; o_gnt=0, o_xfer_req=0, o_xfer_data=0, o_busy=0, o_xfer_id=0, o_err=0; RR pointer=0; all synchroniser flops=0.
- ack_s is i_xfer_ack passed through SYNC_STAGES flops. No other logic samples i_xfer_ack.
- FSM states: IDLE, REQ_HI, WAIT_LO.
- IDLE:
  - i_req is sampled only in IDLE.
  - If any bit is set, the winner is the first set bit searching upward (with wrap) from the RR pointer.
  - At that edge: o_gnt[winner]=1 for exactly one cycle; o_xfer_data=winner's word; o_xfer_id=winner; o_xfer_req=1; RR pointer=(winner+1) mod NUM_REQ; state=REQ_HI.
  - Latency from i_req sampled high to o_gnt/o_xfer_req high is 1 cycle.
- REQ_HI: when ack_s=1, set o_xfer_req=0 and go to WAIT_LO. o_xfer_data must not change.
- WAIT_LO: when ack_s=0, go to IDLE. A new grant is possible in the first IDLE cycle.
- o_busy=1 in REQ_HI and WAIT_LO; o_busy=0 in IDLE.
- Requester rules:
  - Keep i_req and the data word stable until o_gnt.
  - i_req still high in the cycle after o_gnt is a new request; it competes from the updated pointer.
- Simultaneous requests: exactly one grant per handshake. The other requesters wait, and no request is dropped.
- Starvation bound: a held request is granted within NUM_REQ handshakes.
- ack_s=1 already at IDLE entry (protocol violation): a grant still proceeds. REQ_HI then exits on its first cycle.
- Reset mid-transfer: o_xfer_req drops immediately. The destination side must also be reset or must tolerate an abandoned request.
- Without the timeout feature, o_err is tied to 0 and i_err_clr is ignored.

Optional Feature:
- Macro: CDC_XFER_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on each state entry and counts in REQ_HI and WAIT_LO.
  - Counter reaches TIMEOUT_CYC-1 in REQ_HI: o_xfer_req=0, go to WAIT_LO, o_err=1.
  - Counter reaches TIMEOUT_CYC-1 in WAIT_LO: go to IDLE, o_err=1.
  - o_err is sticky until i_err_clr=1. If set and clear occur in the same cycle, set wins.
- Undefined: no counter is built; the handshake waits indefinitely; o_err=0.

Test Plan:
- Single request, ack model echoes o_xfer_req after 3 dest cycles: i_req=4'b0010, word1=8'hA5 -> next cycle o_gnt=4'b0010, o_xfer_data=8'hA5, o_xfer_req=1, o_xfer_id=1. o_xfer_data stays constant until o_xfer_req falls; o_busy falls after ack_s returns to 0.
- All four request continuously from reset -> grant order 0,1,2,3,0,1; exactly one o_gnt pulse per handshake; data words 8'h10..8'h13 appear in the same order.
- Pointer wrap: after granting 3, requests 1 and 3 both high -> grant 1, then 3.
- Reset asserted in REQ_HI -> o_xfer_req, o_gnt and o_busy go to 0 asynchronously. After release with i_req=4'b1000, requester 3 is granted first (pointer reset to 0, no lower request pending).
- Async ack jitter: toggle i_xfer_ack at random phase relative to i_clk -> no grant is lost or duplicated, and o_xfer_data never changes while o_xfer_req=1.
- CDC_XFER_TIMEOUT_EN defined, TIMEOUT_CYC=16, ack held at 0 -> o_xfer_req drops exactly 16 cycles after rising, o_err=1, FSM returns to IDLE. A pulse on i_err_clr sets o_err=0.
